// File: rtl/dmem_sequencer.sv
// rtl/dmem_sequencer.sv - multi-cycle load/store sequencer toward a handshaked data memory
module dmem_sequencer #(
  parameter int ADDR_W  = 9,
  parameter int TIMEOUT = 15
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              MemRead,
  input  logic              MemWrite,
  input  logic [2:0]        Funct3,
  input  logic [31:0]       Addr,
  input  logic [31:0]       WrData,
  output logic [31:0]       RdData,
  output logic              Stall,
  output logic              AccessErr,
  output logic              mem_req,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [3:0]        mem_be,
  output logic [31:0]       mem_wdata,
  input  logic              mem_ack,
  input  logic [31:0]       mem_rdata
);

  localparam int CNT_W = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t              state_q, state_d;
  logic                mem_req_q, mem_req_d;
  logic                mem_we_q, mem_we_d;
  logic [ADDR_W-1:0]   mem_addr_q, mem_addr_d;
  logic [3:0]          mem_be_q, mem_be_d;
  logic [31:0]         mem_wdata_q, mem_wdata_d;
  logic [31:0]         rd_data_q, rd_data_d;
  logic                err_q, err_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic [2:0]          f3_q, f3_d;
  logic [1:0]          off_q, off_d;
  logic                load_q, load_d;

  logic                access;
  logic                load_ok;
  logic                store_ok;
  logic                misalign;
  logic                illegal;
  logic [3:0]          be_new;
  logic [31:0]         wdata_new;
  logic [7:0]          byte_lane;
  logic [15:0]         half_lane;
  logic [31:0]         load_ext;
  logic [31:0]         unused_addr;

  // Upper byte-address bits fall outside the memory's word window.
  assign unused_addr = Addr;

  // Decode the access presented by the memory stage: legality, lanes, store data.
  always_comb begin
    access   = MemRead | MemWrite;
    load_ok  = (Funct3 == 3'b000) || (Funct3 == 3'b001) || (Funct3 == 3'b010) ||
               (Funct3 == 3'b100) || (Funct3 == 3'b101);
    store_ok = (Funct3 == 3'b000) || (Funct3 == 3'b001) || (Funct3 == 3'b010);
    misalign = ((Funct3[1:0] == 2'b01) && Addr[0]) ||
               ((Funct3[1:0] == 2'b10) && (Addr[1:0] != 2'b00));
    illegal  = (MemRead && MemWrite) || (MemRead && !load_ok) ||
               (MemWrite && !store_ok) || misalign;
    be_new    = 4'hF;
    wdata_new = WrData;
    case (Funct3[1:0])
      2'b00: begin
        be_new    = 4'b0001 << Addr[1:0];
        wdata_new = {4{WrData[7:0]}};
      end
      2'b01: begin
        be_new    = Addr[1] ? 4'b1100 : 4'b0011;
        wdata_new = {2{WrData[15:0]}};
      end
      default: begin
        be_new    = 4'hF;
        wdata_new = WrData;
      end
    endcase
  end

  // Pick the addressed lane out of the returned word and extend it by load type.
  always_comb begin
    case (off_q)
      2'd0:    byte_lane = mem_rdata[7:0];
      2'd1:    byte_lane = mem_rdata[15:8];
      2'd2:    byte_lane = mem_rdata[23:16];
      default: byte_lane = mem_rdata[31:24];
    endcase
    half_lane = off_q[1] ? mem_rdata[31:16] : mem_rdata[15:0];
    case (f3_q)
      3'b000:  load_ext = {{24{byte_lane[7]}}, byte_lane};
      3'b001:  load_ext = {{16{half_lane[15]}}, half_lane};
      3'b100:  load_ext = {24'h0, byte_lane};
      3'b101:  load_ext = {16'h0, half_lane};
      default: load_ext = mem_rdata;
    endcase
  end

  // Sequencer next-state and next-register logic; mem_* hold steady while in REQ.
  always_comb begin
    state_d     = state_q;
    mem_req_d   = mem_req_q;
    mem_we_d    = mem_we_q;
    mem_addr_d  = mem_addr_q;
    mem_be_d    = mem_be_q;
    mem_wdata_d = mem_wdata_q;
    rd_data_d   = rd_data_q;
    err_d       = err_q;
    cnt_d       = cnt_q;
    f3_d        = f3_q;
    off_d       = off_q;
    load_d      = load_q;
    case (state_q)
      IDLE: begin
        if (access) begin
          if (illegal) begin
            err_d     = 1'b1;
            rd_data_d = 32'h0;
            state_d   = DONE;
          end else begin
            mem_req_d   = 1'b1;
            mem_we_d    = MemWrite;
            mem_addr_d  = Addr[ADDR_W+1:2];
            mem_be_d    = be_new;
            mem_wdata_d = wdata_new;
            f3_d        = Funct3;
            off_d       = Addr[1:0];
            load_d      = MemRead;
            cnt_d       = '0;
            state_d     = REQ;
          end
        end
      end
      REQ: begin
        // An ack arriving in the final allowed cycle still completes normally.
        if (mem_ack) begin
          mem_req_d = 1'b0;
          mem_we_d  = 1'b0;
          rd_data_d = load_q ? load_ext : 32'h0;
          err_d     = 1'b0;
          state_d   = DONE;
        end else if (cnt_q == CNT_LAST) begin
          mem_req_d = 1'b0;
          mem_we_d  = 1'b0;
          rd_data_d = 32'h0;
          err_d     = 1'b1;
          state_d   = DONE;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      DONE: begin
        err_d   = 1'b0;
        cnt_d   = '0;
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // State and registered memory-side outputs; reset drops any request at once.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      mem_req_q   <= 1'b0;
      mem_we_q    <= 1'b0;
      mem_addr_q  <= '0;
      mem_be_q    <= 4'h0;
      mem_wdata_q <= 32'h0;
      rd_data_q   <= 32'h0;
      err_q       <= 1'b0;
      cnt_q       <= '0;
      f3_q        <= 3'b0;
      off_q       <= 2'b0;
      load_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      mem_req_q   <= mem_req_d;
      mem_we_q    <= mem_we_d;
      mem_addr_q  <= mem_addr_d;
      mem_be_q    <= mem_be_d;
      mem_wdata_q <= mem_wdata_d;
      rd_data_q   <= rd_data_d;
      err_q       <= err_d;
      cnt_q       <= cnt_d;
      f3_q        <= f3_d;
      off_q       <= off_d;
      load_q      <= load_d;
    end
  end

  // Pipeline-facing outputs; Stall is forced low while reset is held.
  always_comb begin
    Stall     = rst_n && (((state_q == IDLE) && access) || (state_q == REQ));
    AccessErr = (state_q == DONE) && err_q;
    RdData    = rd_data_q;
    mem_req   = mem_req_q;
    mem_we    = mem_we_q;
    mem_addr  = mem_addr_q;
    mem_be    = mem_be_q;
    mem_wdata = mem_wdata_q;
  end

endmodule

// File: tb/tb_dmem_sequencer.sv
// tb/tb_dmem_sequencer.sv - table-driven bench for dmem_sequencer
module tb_dmem_sequencer;

  logic        clk;
  logic        rst_n;
  logic        MemRead;
  logic        MemWrite;
  logic [2:0]  Funct3;
  logic [31:0] Addr;
  logic [31:0] WrData;
  logic [31:0] RdData;
  logic        Stall;
  logic        AccessErr;
  logic        mem_req;
  logic        mem_we;
  logic [8:0]  mem_addr;
  logic [3:0]  mem_be;
  logic [31:0] mem_wdata;
  logic        mem_ack;
  logic [31:0] mem_rdata;

  int n_tests;
  int n_fail;

  dmem_sequencer #(.ADDR_W(9), .TIMEOUT(15)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .MemRead   (MemRead),
    .MemWrite  (MemWrite),
    .Funct3    (Funct3),
    .Addr      (Addr),
    .WrData    (WrData),
    .RdData    (RdData),
    .Stall     (Stall),
    .AccessErr (AccessErr),
    .mem_req   (mem_req),
    .mem_we    (mem_we),
    .mem_addr  (mem_addr),
    .mem_be    (mem_be),
    .mem_wdata (mem_wdata),
    .mem_ack   (mem_ack),
    .mem_rdata (mem_rdata)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    string       name;
    logic        rd;
    logic        wr;
    logic [2:0]  f3;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] rdata;
    int          ack_at;     // REQ cycle on which ack is driven, 0 = never
    int          exp_reqc;   // REQ cycles expected (0 = no request)
    logic        exp_we;
    logic [8:0]  exp_addr;
    logic [3:0]  exp_be;
    logic [31:0] exp_wdata;
    logic [31:0] exp_rd;
    logic        exp_err;
  } vec_t;

  vec_t tv[$];

  function automatic vec_t mk(string name, logic rd, logic wr, logic [2:0] f3,
                              logic [31:0] addr, logic [31:0] wdata, logic [31:0] rdata,
                              int ack_at, int exp_reqc, logic exp_we, logic [8:0] exp_addr,
                              logic [3:0] exp_be, logic [31:0] exp_wdata,
                              logic [31:0] exp_rd, logic exp_err);
    vec_t v;
    v.name = name; v.rd = rd; v.wr = wr; v.f3 = f3; v.addr = addr;
    v.wdata = wdata; v.rdata = rdata; v.ack_at = ack_at; v.exp_reqc = exp_reqc;
    v.exp_we = exp_we; v.exp_addr = exp_addr; v.exp_be = exp_be;
    v.exp_wdata = exp_wdata; v.exp_rd = exp_rd; v.exp_err = exp_err;
    return v;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic run_vec(input vec_t v);
    int   stall_cnt;
    int   reqc;
    bit   done;
    bit   stable;
    logic [8:0]  a0;
    logic [3:0]  b0;
    logic        w0;
    logic [31:0] d0;
    stall_cnt = 0; reqc = 0; done = 0; stable = 1;
    a0 = '0; b0 = '0; w0 = 1'b0; d0 = '0;
    @(negedge clk);
    MemRead = v.rd; MemWrite = v.wr; Funct3 = v.f3; Addr = v.addr; WrData = v.wdata;
    for (int c = 0; c < 60; c++) begin
      #1;
      if (Stall) stall_cnt++;
      if (mem_req) begin
        reqc++;
        if (reqc == 1) begin
          a0 = mem_addr; b0 = mem_be; w0 = mem_we; d0 = mem_wdata;
        end else if (mem_addr !== a0 || mem_be !== b0 || mem_we !== w0 || mem_wdata !== d0) begin
          stable = 0;
        end
        if (reqc == v.ack_at) begin
          mem_ack = 1'b1;
          mem_rdata = v.rdata;
        end
      end
      if (!Stall) begin
        done = 1;
        break;
      end
      @(negedge clk);
      mem_ack = 1'b0;
    end
    chk({v.name, " done"}, 32'(done), 32'd1);
    chk({v.name, " req_cycles"}, reqc, v.exp_reqc);
    chk({v.name, " stall_cycles"}, stall_cnt, v.exp_reqc + 1);
    if (v.exp_reqc > 0) begin
      chk({v.name, " mem_addr"}, 32'(a0), 32'(v.exp_addr));
      chk({v.name, " mem_be"}, 32'(b0), 32'(v.exp_be));
      chk({v.name, " mem_we"}, 32'(w0), 32'(v.exp_we));
      chk({v.name, " stable"}, 32'(stable), 32'd1);
      if (v.exp_we) chk({v.name, " mem_wdata"}, d0, v.exp_wdata);
    end
    chk({v.name, " RdData"}, RdData, v.exp_rd);
    chk({v.name, " AccessErr"}, 32'(AccessErr), 32'(v.exp_err));
    chk({v.name, " req_in_done"}, 32'(mem_req), 32'd0);
    MemRead = 1'b0; MemWrite = 1'b0;
    @(negedge clk);
    mem_ack = 1'b0;
    #1;
    chk({v.name, " err_pulse_end"}, 32'(AccessErr), 32'd0);
    chk({v.name, " idle_stall"}, 32'(Stall), 32'd0);
  endtask

  initial begin
    n_tests = 0; n_fail = 0;
    rst_n = 1'b0; MemRead = 1'b0; MemWrite = 1'b0; Funct3 = 3'b0;
    Addr = 32'h0; WrData = 32'h0; mem_ack = 1'b0; mem_rdata = 32'h0;

    //            name        rd wr f3      addr          wdata         rdata      ack rq we addr    be      wdata         rd            err
    tv.push_back(mk("lw_wait3", 1, 0, 3'b010, 32'h10,  32'h0,        32'hDEADBEEF, 3, 3, 0, 9'h004, 4'b1111, 32'h0,        32'hDEADBEEF, 0));
    tv.push_back(mk("sw_mis",   0, 1, 3'b010, 32'h02,  32'h11111111, 32'h0,        0, 0, 0, 9'h000, 4'b0000, 32'h0,        32'h0,        1));
    tv.push_back(mk("lb_b3",    1, 0, 3'b000, 32'h13,  32'h0,        32'h80112233, 1, 1, 0, 9'h004, 4'b1000, 32'h0,        32'hFFFFFF80, 0));
    tv.push_back(mk("lbu_b3",   1, 0, 3'b100, 32'h13,  32'h0,        32'h80112233, 2, 2, 0, 9'h004, 4'b1000, 32'h0,        32'h00000080, 0));
    tv.push_back(mk("rw_both",  1, 1, 3'b010, 32'h00,  32'h0,        32'h0,        0, 0, 0, 9'h000, 4'b0000, 32'h0,        32'h0,        1));
    tv.push_back(mk("lhu_hi",   1, 0, 3'b101, 32'h12,  32'h0,        32'h80112233, 1, 1, 0, 9'h004, 4'b1100, 32'h0,        32'h00008011, 0));
    tv.push_back(mk("lh_hi",    1, 0, 3'b001, 32'h12,  32'h0,        32'h80112233, 1, 1, 0, 9'h004, 4'b1100, 32'h0,        32'hFFFF8011, 0));
    tv.push_back(mk("lh_lo",    1, 0, 3'b001, 32'h10,  32'h0,        32'h1234F00D, 1, 1, 0, 9'h004, 4'b0011, 32'h0,        32'hFFFFF00D, 0));
    tv.push_back(mk("lb_b1",    1, 0, 3'b000, 32'h11,  32'h0,        32'h80112233, 1, 1, 0, 9'h004, 4'b0010, 32'h0,        32'h00000022, 0));
    tv.push_back(mk("sh_hi",    0, 1, 3'b001, 32'h06,  32'h1234ABCD, 32'h0,        2, 2, 1, 9'h001, 4'b1100, 32'hABCDABCD, 32'h0,        0));
    tv.push_back(mk("sb_b1",    0, 1, 3'b000, 32'h05,  32'h000000A5, 32'h0,        1, 1, 1, 9'h001, 4'b0010, 32'hA5A5A5A5, 32'h0,        0));
    tv.push_back(mk("lw_top",   1, 0, 3'b010, 32'h7FC, 32'h0,        32'h01234567, 1, 1, 0, 9'h1FF, 4'b1111, 32'h0,        32'h01234567, 0));
    tv.push_back(mk("sw_ok",    0, 1, 3'b010, 32'h08,  32'hCAFEF00D, 32'h0,        1, 1, 1, 9'h002, 4'b1111, 32'hCAFEF00D, 32'h0,        0));
    tv.push_back(mk("lw_f3bad", 1, 0, 3'b011, 32'h00,  32'h0,        32'h0,        0, 0, 0, 9'h000, 4'b0000, 32'h0,        32'h0,        1));
    tv.push_back(mk("s_f3bad",  0, 1, 3'b100, 32'h00,  32'h0,        32'h0,        0, 0, 0, 9'h000, 4'b0000, 32'h0,        32'h0,        1));
    tv.push_back(mk("lh_mis",   1, 0, 3'b001, 32'h01,  32'h0,        32'h0,        0, 0, 0, 9'h000, 4'b0000, 32'h0,        32'h0,        1));
    tv.push_back(mk("lw_pre",   1, 0, 3'b010, 32'h24,  32'h0,        32'h55AA55AA, 1, 1, 0, 9'h009, 4'b1111, 32'h0,        32'h55AA55AA, 0));
    tv.push_back(mk("lw_tmo",   1, 0, 3'b010, 32'h20,  32'h0,        32'h0,        0, 15, 0, 9'h008, 4'b1111, 32'h0,       32'h0,        1));
    tv.push_back(mk("lw_ack15", 1, 0, 3'b010, 32'h24,  32'h0,        32'h5A5A0001, 15, 15, 0, 9'h009, 4'b1111, 32'h0,      32'h5A5A0001, 0));

    // Reset state
    repeat (2) @(negedge clk);
    #1;
    chk("rst mem_req", 32'(mem_req), 32'd0);
    chk("rst mem_we", 32'(mem_we), 32'd0);
    chk("rst mem_addr", 32'(mem_addr), 32'd0);
    chk("rst mem_be", 32'(mem_be), 32'd0);
    chk("rst mem_wdata", mem_wdata, 32'd0);
    chk("rst RdData", RdData, 32'd0);
    chk("rst Stall", 32'(Stall), 32'd0);
    chk("rst AccessErr", 32'(AccessErr), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;

    foreach (tv[i]) run_vec(tv[i]);

    // Reset asserted mid-REQ of a store, then a stray ack after release
    @(negedge clk);
    MemWrite = 1'b1; Funct3 = 3'b010; Addr = 32'h08; WrData = 32'h13572468;
    @(negedge clk);
    #1;
    chk("mid_rst req_before", 32'(mem_req), 32'd1);
    chk("mid_rst we_before", 32'(mem_we), 32'd1);
    rst_n = 1'b0;
    #1;
    chk("mid_rst req_async", 32'(mem_req), 32'd0);
    chk("mid_rst we_async", 32'(mem_we), 32'd0);
    chk("mid_rst stall", 32'(Stall), 32'd0);
    @(negedge clk);
    rst_n = 1'b1; MemWrite = 1'b0;
    mem_ack = 1'b1; mem_rdata = 32'hFFFFFFFF;
    @(negedge clk);
    mem_ack = 1'b0;
    #1;
    chk("late_ack req", 32'(mem_req), 32'd0);
    chk("late_ack stall", 32'(Stall), 32'd0);
    chk("late_ack err", 32'(AccessErr), 32'd0);
    chk("late_ack RdData", RdData, 32'd0);

    // Recovery: zero-wait load right after
    run_vec(mk("lbu_after_rst", 1, 0, 3'b100, 32'h01, 32'h0, 32'h0000C300, 1, 1, 0, 9'h000,
               4'b0010, 32'h0, 32'h000000C3, 0));

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/dmem_sequencer.md
# dmem_sequencer

Multi-cycle data-memory access sequencer sitting between the core's memory stage (driven by the decoder's MemRead/MemWrite) and a handshaked data memory with variable latency. Converts each load/store (lb/lh/lw/lbu/lhu, sb/sh/sw) into one req/ack transaction with byte enables, stalls the pipeline until completion, and returns the sign- or zero-extended load result. Flags misaligned, illegal and timed-out accesses without issuing or completing a memory write.

## Interface
- ADDR_W, 9: word-address width driven to memory (mem_addr = Addr[ADDR_W+1:2]).
- TIMEOUT, 15: max REQ cycles without ack before abort; ≥1.
- clk  in  1  clock, all state on rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- MemRead  in  1  load in memory stage.
- MemWrite  in  1  store in memory stage.
- Funct3  in  3  access size/sign.
- Addr  in  32  byte address from ALU.
- WrData  in  32  store data (rs2).
- RdData  out  32  extended load result; valid in DONE.
- Stall  out  1  freeze pipeline when high.
- AccessErr  out  1  one-cycle pulse in DONE for a failed access.
- mem_req  out  1  request, registered.
- mem_we  out  1  write request, registered.
- mem_addr  out  ADDR_W  word address, registered.
- mem_be  out  4  byte enables, registered.
- mem_wdata  out  32  lane-replicated store data, registered.
- mem_ack  in  1  memory completion, one cycle.
- mem_rdata  in  32  read word, valid with mem_ack.

## Operation
- States: IDLE, REQ, DONE. Reset → IDLE; all registered outputs 0, RdData 0, timeout counter 0.
- IDLE: access = MemRead|MemWrite. Legal and aligned → load mem_* registers, mem_req=1, → REQ. Illegal → skip memory, → DONE with err flag set.
- Illegal: MemRead&MemWrite both 1; load Funct3 ∉ {000,001,010,100,101}; store Funct3 ∉ {000,001,010}; halfword with Addr[0]=1; word with Addr[1:0]≠00.
- Byte enables: byte → 4'b0001<<Addr[1:0]; half → Addr[1]?1100:0011; word → 1111; loads use same be, mem_we=0.
- mem_wdata: byte → {4{WrData[7:0]}}; half → {2{WrData[15:0]}}; word → WrData.
- REQ: mem_req and all mem_* held stable until mem_ack sampled 1. On ack: mem_req=0, mem_we=0; load → capture extracted lane (byte at Addr[1:0], half at Addr[1]) sign-extended (lb/lh) or zero-extended (lbu/lhu, lw unchanged) into RdData; → DONE.
- Timeout: counter increments each REQ cycle without ack; reaching TIMEOUT → drop mem_req, RdData=0, err set, → DONE. Ack in that same cycle wins (normal completion).
- DONE: Stall=0, AccessErr=err, RdData held; next cycle → IDLE, err cleared, counter cleared. Stores and errors present RdData=0.
- Stall = (IDLE & access) | REQ; 0 in DONE and while rst_n=0.
- mem_ack in IDLE or DONE ignored.

## Timing
- Zero-wait memory (ack cycle after req rises): access seen cycle 0, req high cycle 1, ack cycle 1, DONE cycle 2. Stall high cycles 0–1.
- General: stall cycles = 1 + cycles in REQ; result usable in DONE cycle, latched by pipeline there.
- Back-to-back accesses: DONE → IDLE costs one cycle; new instruction evaluated in IDLE.
- Illegal access: IDLE → DONE, Stall one cycle, no mem_req.
- rst_n low mid-REQ: immediate return to IDLE, mem_req/mem_we 0 asynchronously; late ack after release ignored.

## Test plan
- lw Addr=0x10, ack after 3 REQ cycles, mem_rdata=0xDEADBEEF → mem_addr=4, be=1111, Stall 4 cycles, RdData=0xDEADBEEF in DONE, AccessErr=0.
- lb Addr=0x13, mem_rdata=0x80112233 → be=1000, RdData=0xFFFFFF80; lbu same → 0x00000080; lhu Addr=0x12 → 0x00008011.
- sh Addr=0x06, WrData=0x1234ABCD → mem_we=1, be=1100, mem_wdata=0xABCDABCD, RdData=0.
- sw Addr=0x02 → no mem_req, Stall 1 cycle, AccessErr pulse 1 cycle; MemRead=MemWrite=1 same result.
- No ack, TIMEOUT=15 → mem_req drops after 15 REQ cycles, AccessErr=1, RdData=0; ack on 15th cycle → normal completion instead.
- rst_n low during REQ, then ack → mem_req 0 immediately, state IDLE, ack ignored, RdData=0.
